// File: rtl/key_irq_ctrl_pkg.sv
// key_irq_ctrl_pkg
//   Shared constants for the user-key interrupt controller: the bus window,
//   register word selects and the EDGE field encoding.
//   No ports; imported by key_irq_ctrl and key_debounce.
package key_irq_ctrl_pkg;

  localparam logic [31:0] KEYIRQ_BEGIN = 32'h0000_7F60;
  localparam logic [31:0] KEYIRQ_END   = 32'h0000_7F6F;

  // Byte offsets inside the window
  localparam logic [3:0] OFS_STATUS  = 4'h0;
  localparam logic [3:0] OFS_PENDING = 4'h4;
  localparam logic [3:0] OFS_MASK    = 4'h8;
  localparam logic [3:0] OFS_CTRL    = 4'hC;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_PENDING = 2'd1,
    REG_MASK    = 2'd2,
    REG_CTRL    = 2'd3
  } reg_sel_e;

  typedef enum logic [1:0] {
    EDGE_NONE    = 2'b00,
    EDGE_PRESS   = 2'b01,
    EDGE_RELEASE = 2'b10,
    EDGE_BOTH    = 2'b11
  } edge_sel_e;

  function automatic logic in_window(input logic [31:0] addr);
    return (addr >= KEYIRQ_BEGIN) && (addr <= KEYIRQ_END);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
//   Synchronizes one raw active-low key and accepts a level change only after
//   DB_CNT consecutive cycles of the new synchronized level.
//   clk      : system clock
//   reset    : async active-low reset
//   key_raw  : raw key, active-low, asynchronous to clk
//   stable   : debounced level, 1 = pressed
module key_debounce
  import key_irq_ctrl_pkg::*;
#(
  parameter int DB_CNT = 250000,
  parameter int CNT_W  = $clog2(DB_CNT)
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic stable
);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt     <= '0;
      stable  <= 1'b0;
    end else begin
      // Inversion ahead of the synchronizer so everything downstream is 1 = pressed
      sync_q1 <= ~key_raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CNT - 1)) begin
        stable <= sync_q2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_irq_ctrl.sv
// key_irq_ctrl
//   Debounced edge-interrupt controller for the eight user keys.
//   clk      : system clock
//   reset    : async active-low reset
//   Address  : byte address from the bus bridge (window decoded here)
//   WD       : write data
//   WE       : byte write enables (only lane 0 carries register bits)
//   user_key : raw keys, active-low, asynchronous
//   RD       : combinational read data, 0 outside the window
//   irq      : registered level interrupt request, active-high
module key_irq_ctrl
  import key_irq_ctrl_pkg::*;
#(
  parameter int DB_CNT = 250000,
  parameter int CNT_W  = $clog2(DB_CNT)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WD,
  input  logic [3:0]  WE,
  input  logic [7:0]  user_key,
  output logic [31:0] RD,
  output logic        irq
);

  logic [7:0] stable;
  logic [7:0] stable_d;
  logic [7:0] pending;
  logic [7:0] mask;
  logic       ctrl_en;
  logic [1:0] ctrl_edge;

  logic       hit;
  reg_sel_e   sel;
  logic       wr_lane0;
  logic [7:0] press;
  logic [7:0] release_ev;
  logic [7:0] events;
  logic [7:0] w1c;
  logic       unused_bits;

  for (genvar i = 0; i < 8; i++) begin : g_key
    key_debounce #(
      .DB_CNT (DB_CNT),
      .CNT_W  (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .key_raw (user_key[i]),
      .stable  (stable[i])
    );
  end

  assign hit         = in_window(Address);
  assign sel         = reg_sel_e'(Address[3:2]);
  assign wr_lane0    = hit & WE[0];
  assign unused_bits = ^{WD[31:8], WE[3:1]};

  assign press      = stable & ~stable_d;
  assign release_ev = ~stable & stable_d;
  assign events     = (ctrl_edge[0] ? press      : 8'h00) |
                      (ctrl_edge[1] ? release_ev : 8'h00);

  assign w1c = (wr_lane0 && sel == REG_PENDING) ? WD[7:0] : 8'h00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_d  <= '0;
      pending   <= '0;
      mask      <= '0;
      ctrl_en   <= 1'b0;
      ctrl_edge <= EDGE_NONE;
      irq       <= 1'b0;
    end else begin
      stable_d <= stable;
      // OR-ing events after the clear makes a concurrent event win over W1C
      pending  <= (pending & ~w1c) | events;
      if (wr_lane0 && sel == REG_MASK) begin
        mask <= WD[7:0];
      end
      if (wr_lane0 && sel == REG_CTRL) begin
        ctrl_en   <= WD[0];
        ctrl_edge <= WD[2:1];
      end
      irq <= ctrl_en & (|(pending & mask));
    end
  end

  always_comb begin
    RD = 32'h0;
    if (hit) begin
      case (sel)
        REG_STATUS:  RD = {24'h0, stable};
        REG_PENDING: RD = {24'h0, pending};
        REG_MASK:    RD = {24'h0, mask};
        REG_CTRL:    RD = {29'h0, ctrl_edge, ctrl_en};
        default:     RD = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_key_irq_ctrl.sv
module tb_key_irq_ctrl;
  import key_irq_ctrl_pkg::*;

  localparam int DB = 4;
  localparam logic [31:0] A_STATUS  = KEYIRQ_BEGIN + 32'(OFS_STATUS);
  localparam logic [31:0] A_PENDING = KEYIRQ_BEGIN + 32'(OFS_PENDING);
  localparam logic [31:0] A_MASK    = KEYIRQ_BEGIN + 32'(OFS_MASK);
  localparam logic [31:0] A_CTRL    = KEYIRQ_BEGIN + 32'(OFS_CTRL);

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WD;
  logic [3:0]  WE;
  logic [7:0]  user_key;
  logic [31:0] RD;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  key_irq_ctrl #(.DB_CNT(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WD       (WD),
    .WE       (WE),
    .user_key (user_key),
    .RD       (RD),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  we;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
    @(negedge clk);
    Address = addr;
    WD      = data;
    WE      = we;
    @(posedge clk);
    #1;
    WE = 4'h0;
  endtask

  task automatic read_check(input logic [31:0] addr, input logic [31:0] exp, input string name);
    Address = addr;
    #1;
    check(name, RD, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"mask_wr",        A_MASK,           32'h0000_00A5, 4'h1, 32'h0000_00A5};
    vecs[1]  = '{"mask_upper_ign", A_MASK,           32'hFFFF_FF3C, 4'hF, 32'h0000_003C};
    vecs[2]  = '{"mask_lane0_off", A_MASK,           32'h0000_0011, 4'hE, 32'h0000_003C};
    vecs[3]  = '{"ctrl_rd",        A_CTRL,           32'h0,         4'h0, 32'h0000_0000};
    vecs[4]  = '{"ctrl_unused",    A_CTRL,           32'h0000_00FF, 4'h1, 32'h0000_0007};
    vecs[5]  = '{"ctrl_edge_rel",  A_CTRL,           32'h0000_0004, 4'h1, 32'h0000_0004};
    vecs[6]  = '{"status_wr_ign",  A_STATUS,         32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[7]  = '{"pend_w1c_idle",  A_PENDING,        32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
    vecs[8]  = '{"mask_kept",      A_MASK,           32'h0,         4'h0, 32'h0000_003C};
    vecs[9]  = '{"rd_above",       KEYIRQ_END + 1,   32'h0,         4'h0, 32'h0000_0000};
    vecs[10] = '{"rd_below",       KEYIRQ_BEGIN - 4, 32'h0,         4'h0, 32'h0000_0000};
    vecs[11] = '{"mask_all",       A_MASK,           32'h0000_00FF, 4'h1, 32'h0000_00FF};
    vecs[12] = '{"ctrl_all",       A_CTRL,           32'h0000_0007, 4'h1, 32'h0000_0007};

    reset    = 1'b0;
    Address  = A_STATUS;
    WD       = 32'h0;
    WE       = 4'h0;
    user_key = 8'hFF;

    // 1. reset then idle
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_irq", {31'h0, irq}, 32'h0);
      check("rst_status", RD, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_status", RD, 32'h0);
      check("idle_irq", {31'h0, irq}, 32'h0);
    end
    read_check(A_PENDING, 32'h0, "idle_pending");
    read_check(A_MASK,    32'h0, "idle_mask");
    read_check(A_CTRL,    32'h0, "idle_ctrl");

    // register access table
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].we != 4'h0) begin
        bus_write(vecs[i].addr, vecs[i].wd, vecs[i].we);
      end else begin
        @(negedge clk);
        Address = vecs[i].addr;
      end
      read_check(vecs[i].addr, vecs[i].exp_rd, vecs[i].name);
    end

    // 2. glitch rejection (EN, both edges, all unmasked)
    @(negedge clk);
    user_key[0] = 1'b0;
    repeat (3) @(negedge clk);
    user_key[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      Address = A_STATUS;
      #1;
      check("glitch_status", RD, 32'h0);
      check("glitch_irq", {31'h0, irq}, 32'h0);
    end
    read_check(A_PENDING, 32'h0, "glitch_pending");

    // 3. press interrupt
    bus_write(A_CTRL, 32'h3, 4'h1);
    bus_write(A_MASK, 32'h1, 4'h1);
    @(negedge clk);
    user_key[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) check("press_irq_c7", {31'h0, irq}, 32'h0);
      if (i == 8) check("press_irq_c8", {31'h0, irq}, 32'h1);
    end
    read_check(A_STATUS,  32'h01, "press_status");
    read_check(A_PENDING, 32'h01, "press_pending");
    bus_write(A_PENDING, 32'h1, 4'h1);
    read_check(A_PENDING, 32'h00, "w1c_pending");
    check("w1c_irq_hold", {31'h0, irq}, 32'h1);
    tick();
    check("w1c_irq_low", {31'h0, irq}, 32'h0);
    @(negedge clk);
    user_key[0] = 1'b1;
    repeat (10) tick();
    read_check(A_PENDING, 32'h00, "press_only_no_rel");

    // 4. mask and late unmask
    bus_write(A_MASK, 32'h0, 4'h1);
    @(negedge clk);
    user_key[5] = 1'b0;
    repeat (10) tick();
    read_check(A_PENDING, 32'h20, "masked_pending");
    read_check(A_STATUS,  32'h20, "masked_status");
    check("masked_irq", {31'h0, irq}, 32'h0);
    bus_write(A_MASK, 32'h20, 4'h1);
    check("unmask_irq_c1", {31'h0, irq}, 32'h0);
    tick();
    check("unmask_irq_c2", {31'h0, irq}, 32'h1);
    @(negedge clk);
    user_key[5] = 1'b1;
    repeat (10) tick();
    read_check(A_PENDING, 32'h20, "unmask_pend_kept");
    bus_write(A_PENDING, 32'h20, 4'h1);
    read_check(A_PENDING, 32'h00, "unmask_pend_clr");

    // 5. set beats clear on key 2 release
    bus_write(A_CTRL, 32'h7, 4'h1);
    @(negedge clk);
    user_key[2] = 1'b0;
    repeat (10) tick();
    read_check(A_PENDING, 32'h04, "both_press_pend");
    @(negedge clk);
    user_key[2] = 1'b1;
    // release event is live in the cycle ending at the 7th edge
    repeat (6) @(posedge clk);
    bus_write(A_PENDING, 32'h04, 4'h1);
    read_check(A_PENDING, 32'h04, "set_beats_clear");
    read_check(A_STATUS,  32'h00, "release_status");

    // 6. reset mid-debounce
    bus_write(A_MASK, 32'h24, 4'h1);
    tick();
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    @(negedge clk);
    user_key[7] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_irq", {31'h0, irq}, 32'h0);
    read_check(A_STATUS,  32'h0, "async_rst_status");
    read_check(A_PENDING, 32'h0, "async_rst_pending");
    read_check(A_MASK,    32'h0, "async_rst_mask");
    read_check(A_CTRL,    32'h0, "async_rst_ctrl");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    Address = A_STATUS;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) check("rst_held_c5", RD, 32'h00);
      if (i == 6) check("rst_held_c6", RD, 32'h80);
    end
    repeat (3) tick();
    read_check(A_PENDING, 32'h00, "edge_none_pending");
    check("edge_none_irq", {31'h0, irq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_irq_ctrl.md
# key_irq_ctrl

Interrupt controller for the board's eight user keys, sitting beside the GPIO bridge on the CPU's peripheral bus. It synchronizes and debounces the raw active-low keys, detects press and release edges, and latches them into write-1-to-clear pending bits. It drives a single level interrupt request to the CPU's exception unit, so programs no longer need to poll the key register.

## Interface
- `DB_CNT`, default 250000: stable cycles required before a key change is accepted (10 ms at 25 MHz). Range is 2 or more.
- `CNT_W`, default $clog2(DB_CNT): width of each debounce counter.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-low reset. 0 means reset.
- `Address`  input  32  byte address from the bridge. The block decodes its own window.
- `WD`  input  32  write data.
- `WE`  input  4  byte write enables. These are already qualified by the bridge's address decode for this window.
- `user_key`  input  8  raw board keys, active-low, asynchronous to `clk`.
- `RD`  output  32  read data, combinational. Returns 0 outside the window.
- `irq`  output  1  registered interrupt request, active-high.

## Operation
- Register window: `KEYIRQ_Begin` to `KEYIRQ_End`, word-aligned. Offsets:
  - +0x0 STATUS (RO): bits [7:0] are the debounced levels, 1 = pressed.
  - +0x4 PENDING (W1C): bits [7:0].
  - +0x8 MASK (RW): bits [7:0].
  - +0xC CTRL (RW): bit0 EN, bits [2:1] EDGE. EDGE encoding: 00 none, 01 press, 10 release, 11 both.
- Register access rules:
  - Reads of unused bits return 0.
  - Writes to STATUS are ignored.
  - Byte lanes are honoured per `WE`. Only lane 0 matters.
- Per key i, in order:
  - Two-flop synchronizer on `~user_key[i]`, giving `sync[i]`.
  - Debounce: if `sync[i] == stable[i]`, `cnt[i]` is cleared to 0. Otherwise `cnt[i]` increments.
  - When `cnt[i] == DB_CNT-1` and the levels still differ, `stable[i]` takes `sync[i]` and `cnt[i]` returns to 0.
  - A glitch shorter than `DB_CNT` cycles never reaches `stable`.
  - Edge detect: `stable_d[i]` is `stable[i]` delayed one cycle. Press is `stable & ~stable_d`. Release is `~stable & stable_d`.
  - `pending[i]` sets on each event selected by EDGE. EDGE = 00 sets nothing.
- PENDING update, per bit, evaluated in this order:
  - If an event occurs in the same cycle as a W1C on that bit, the set wins and the bit stays 1.
  - W1C of a bit with no concurrent event clears it.
  - Writing 0 has no effect.
  - Pending bits latch regardless of MASK and EN. Unmasking later raises `irq` if a bit is already pending.
- `irq` is the register of `EN & |(PENDING & MASK)`.
- Reset values:
  - Synchronizer flops 0; `stable`, `stable_d` and `cnt` all 0.
  - PENDING, MASK and CTRL 0.
  - `irq` 0.
  - `RD` follows the register contents, so STATUS reads 0.
- Reset asserted mid-debounce aborts the count. A key still held when reset releases produces a press event after `DB_CNT` cycles.

## Timing
- Raw edge to `sync` change: 2 cycles, plus up to 1 cycle of metastability uncertainty.
- `sync` change to `stable` change: exactly `DB_CNT` cycles of constant `sync`.
- `stable` change to `pending` set: 1 cycle.
- `pending` set to `irq` high: 1 cycle.
- Total latency from raw edge to `irq`: `DB_CNT` + 4 cycles, with one cycle of jitter from the synchronizer.
- A W1C write or a MASK/EN write takes effect on `PENDING`/`MASK`/`CTRL` at the next edge, and on `irq` one edge after that.
- `RD` is combinational on `Address`. The bus samples it in the same cycle, matching the other peripherals.

## Structure
- The shared `macro.v` holds:
  - `KEYIRQ_Begin` and `KEYIRQ_End`.
  - Offset constants STATUS/PENDING/MASK/CTRL.
  - EDGE encodings.
- Sub-module `key_debounce`: one per key, instantiated 8 times.
  - Parameters: `DB_CNT` and `CNT_W`.
  - Contains the synchronizer, counter and `stable` output.
- The top level holds edge detect, the register file, read mux and `irq`.

## Test plan
Simulate with `DB_CNT`=4.
1. Reset then idle: `reset`=0 for 3 cycles with all keys released, then release reset. Required: `irq`=0, all reads 0, and STATUS=0x00 for 20 cycles.
2. Glitch rejection: pulse `user_key[0]` low for 3 cycles. Required: STATUS stays 0x00 and PENDING stays 0x00.
3. Press interrupt: CTRL=0x3 (EN, press) and MASK=0x01, then hold `user_key[0]` low. Required: STATUS=0x01, PENDING=0x01, and `irq`=1 by cycle 8 after the edge. Then W1C 0x01 to PENDING. Required: PENDING=0x00 next cycle and `irq`=0 the cycle after.
4. Mask and late unmask: with MASK=0x00, press key 5. Required: PENDING=0x20 and `irq`=0. Then write MASK=0x20. Required: `irq`=1 two cycles later.
5. Set beats clear: with EDGE=11, time the W1C of bit 2 to the same cycle as key 2's release event. Required: PENDING bit 2 remains 1.
6. Reset mid-debounce: hold key 7 low, then assert `reset` at count 2. Required: all state is 0 immediately, with no clock needed. After release, STATUS=0x80 exactly `DB_CNT` cycles after `sync` settles.
